uart_tx_arbiter: RTL and testbench

//  Shares a single UART transmitter between NUM_REQ byte producers.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit-side blocks.
// The arbiter state encoding is exported so checkers can bind to it.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set valid bit scanning upward
// from last_grant+1, wrapping modulo NUM_REQ.
module uart_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      last_grant,
   output logic [IW-1:0]      winner,
   output logic               any_valid
);

   int            idx;
   logic [IW-1:0] idx_b;
   logic          found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      idx_b  = '0;
      // Offset 1 first so the previous winner is considered last.
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx   = (int'(last_grant) + off) % NUM_REQ;
         idx_b = IW'(idx);
         if (!found && req_valid[idx_b]) begin
            found  = 1'b1;
            winner = idx_b;
         end
      end
      any_valid = |req_valid;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ producers:
// picks, latches and launches a byte, then follows tx_busy to frame end.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int BUSY_TMO   = 64,
   localparam int IW         = $clog2(NUM_REQ),
   localparam int CW         = $clog2(BUSY_TMO)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          tx_busy,
   output logic                          tx_data_valid,
   output logic [DATA_WIDTH-1:0]         tx_p_data,
   output logic [IW-1:0]                 grant_id,
   output logic                          frame_done,
   output logic                          tmo_err,
   output tx_arb_state_e                 state_dbg
);

   // Handshake: req_valid[i] is a level held by producer i; the byte on
   // req_data[i] transfers in the single cycle where req_valid[i] and
   // req_ready[i] are both high. tx_data_valid is a one-cycle launch with no
   // ready; the TX core acknowledges by raising tx_busy, and the frame ends
   // when tx_busy falls.

   localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TMO - 1);

   tx_arb_state_e         state;
   logic [IW-1:0]         last_grant;
   logic [IW-1:0]         winner;
   logic                  any_valid;
   logic [CW-1:0]         cnt;
   logic                  pick;
   logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   uart_rr_pick #(
      .NUM_REQ    (NUM_REQ)
   ) u_pick (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .winner     (winner),
      .any_valid  (any_valid)
   );

   // A foreign frame on the TX core blocks granting entirely.
   assign pick = (state == IDLE) && any_valid && !tx_busy;

   // Gated by rst so no accept is signalled while reset is held.
   always_comb begin
      req_ready = '0;
      if (pick && rst) req_ready[winner] = 1'b1;
   end

   assign tx_data_valid = (state == LAUNCH);
   assign frame_done    = (state == WAIT_DONE) && !tx_busy;
   assign tmo_err       = (state == WAIT_BUSY) && !tx_busy && (cnt == CNT_LAST);
   assign state_dbg     = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= IW'(NUM_REQ - 1);
         grant_id   <= '0;
         tx_p_data  <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick) begin
                  tx_p_data <= req_bytes[winner];
                  grant_id  <= winner;
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt   <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // Timed-out bytes are dropped; the pointer still advances.
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (cnt == CNT_LAST) begin
                  last_grant <= grant_id;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  last_grant <= grant_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner
// sequences, then randomized traffic against a transaction-level model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int TMO = 64;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [NR*DW-1:0]   req_data  = '0;
   logic [NR-1:0]      req_ready;
   logic               tx_busy = 1'b0;
   logic               tx_data_valid;
   logic [DW-1:0]      tx_p_data;
   logic [1:0]         grant_id;
   logic               frame_done;
   logic               tmo_err;
   tx_arb_state_e      state_dbg;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   localparam logic [NR*DW-1:0] STD_DATA = {8'h44, 8'h33, 8'h22, 8'h11};

   uart_tx_arbiter #(
      .NUM_REQ       (NR),
      .DATA_WIDTH    (DW),
      .BUSY_TMO      (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .tx_busy       (tx_busy),
      .tx_data_valid (tx_data_valid),
      .tx_p_data     (tx_p_data),
      .grant_id      (grant_id),
      .frame_done    (frame_done),
      .tmo_err       (tmo_err),
      .state_dbg     (state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Inputs change just after the active edge, outputs are read on the falling edge.
   task automatic drive_slot();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_slot();
      @(negedge clk);
   endtask

   // Reference: nearest valid requester strictly after ptr, going round the ring.
   function automatic int rr_ref(input int ptr, input logic [NR-1:0] v);
      for (int d = 1; d <= NR; d++)
         if (v[(ptr + d) % NR]) return (ptr + d) % NR;
      return -1;
   endfunction

   // Called in the accept cycle's falling half; runs launch, busy and done.
   task automatic launch_and_finish(input string tag, input logic [DW-1:0] ed,
                                    input logic [1:0] eg, input int blen, input bit drop);
      drive_slot();
      if (drop) req_valid = '0;
      sample_slot();
      chk({tag, "_launch"}, 32'(tx_data_valid), 32'd1);
      chk({tag, "_data"}, 32'(tx_p_data), 32'(ed));
      chk({tag, "_grant"}, 32'(grant_id), 32'(eg));
      chk({tag, "_ready_launch"}, 32'(req_ready), 32'd0);
      for (int k = 0; k < blen; k++) begin
         drive_slot();
         tx_busy = 1'b1;
         sample_slot();
         chk({tag, "_done_early"}, 32'(frame_done), 32'd0);
         chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      end
      drive_slot();
      tx_busy = 1'b0;
      sample_slot();
      chk({tag, "_done"}, 32'(frame_done), 32'd1);
      chk({tag, "_hold"}, 32'(tx_p_data), 32'(ed));
   endtask

   typedef struct {
      logic [NR-1:0] valid;
      logic [NR-1:0] exp_ready;
      logic [1:0]    exp_grant;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vecs [12];

   initial begin
      // randomized-phase model state
      int            m_ptr;
      int            m_grant;
      int            since;
      int            busy_start;
      int            busy_end;
      int            w;
      bit            pending;
      bit            launch_due;
      bit            busy_seen;
      bit            exp_done;
      bit            exp_tmo;
      logic [NR-1:0] acc;
      logic [NR-1:0] exp_ready;
      logic [DW-1:0] exp_byte;

      vecs[0]  = '{4'b1111, 4'b0001, 2'd0, 8'h11};
      vecs[1]  = '{4'b1111, 4'b0010, 2'd1, 8'h22};
      vecs[2]  = '{4'b1111, 4'b0100, 2'd2, 8'h33};
      vecs[3]  = '{4'b1111, 4'b1000, 2'd3, 8'h44};
      vecs[4]  = '{4'b1111, 4'b0001, 2'd0, 8'h11};
      vecs[5]  = '{4'b0011, 4'b0010, 2'd1, 8'h22};
      vecs[6]  = '{4'b0011, 4'b0001, 2'd0, 8'h11};
      vecs[7]  = '{4'b0011, 4'b0010, 2'd1, 8'h22};
      vecs[8]  = '{4'b1000, 4'b1000, 2'd3, 8'h44};
      vecs[9]  = '{4'b1001, 4'b0001, 2'd0, 8'h11};
      vecs[10] = '{4'b0110, 4'b0010, 2'd1, 8'h22};
      vecs[11] = '{4'b0101, 4'b0100, 2'd2, 8'h33};

      // reset with all requesters pending: nothing may be granted
      req_valid = 4'b1111;
      req_data  = STD_DATA;
      repeat (3) sample_slot();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_launch", 32'(tx_data_valid), 32'd0);
      chk("rst_data", 32'(tx_p_data), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_tmo", 32'(tmo_err), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'(IDLE));
      drive_slot();
      rst       = 1'b1;
      req_valid = '0;
      sample_slot();

      // round-robin order and wrap-around
      for (int i = 0; i < 12; i++) begin
         drive_slot();
         req_valid = vecs[i].valid;
         tx_busy   = 1'b0;
         sample_slot();
         chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
         launch_and_finish($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_grant, 1 + i % 3, 1'b0);
      end

      // lone requester, drops valid after accept, 10-cycle frame
      drive_slot();
      req_valid = 4'b0001;
      req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
      sample_slot();
      chk("t1_ready", 32'(req_ready), 32'b0001);
      launch_and_finish("t1", 8'hA5, 2'd0, 10, 1'b1);
      drive_slot();
      sample_slot();
      chk("t1_idle_hold", 32'(tx_p_data), 32'hA5);
      chk("t1_idle_done", 32'(frame_done), 32'd0);

      // busy never rises: timeout, then the next requester in turn
      drive_slot();
      req_valid = 4'b1010;
      req_data  = STD_DATA;
      sample_slot();
      chk("t4_ready", 32'(req_ready), 32'b0010);
      drive_slot();
      sample_slot();
      chk("t4_launch", 32'(tx_data_valid), 32'd1);
      chk("t4_data", 32'(tx_p_data), 32'h22);
      for (int k = 1; k <= TMO; k++) begin
         drive_slot();
         sample_slot();
         if (k >= TMO - 1) chk($sformatf("t4_tmo_k%0d", k), 32'(tmo_err), 32'(k == TMO));
         else if (tmo_err !== 1'b0) chk($sformatf("t4_tmo_k%0d", k), 32'(tmo_err), 32'd0);
         if (req_ready !== '0) chk($sformatf("t4_ready_k%0d", k), 32'(req_ready), 32'd0);
      end
      drive_slot();
      sample_slot();
      chk("t4_next_ready", 32'(req_ready), 32'b1000);
      chk("t4_state", 32'(state_dbg), 32'(IDLE));
      launch_and_finish("t4n", 8'h44, 2'd3, 2, 1'b0);

      // foreign frame in IDLE blocks the grant
      drive_slot();
      req_valid = 4'b1000;
      tx_busy   = 1'b1;
      sample_slot();
      chk("t5_block0", 32'(req_ready), 32'd0);
      for (int k = 1; k < 3; k++) begin
         drive_slot();
         sample_slot();
         chk($sformatf("t5_block%0d", k), 32'(req_ready), 32'd0);
      end
      drive_slot();
      tx_busy = 1'b0;
      sample_slot();
      chk("t5_ready", 32'(req_ready), 32'b1000);
      launch_and_finish("t5", 8'h44, 2'd3, 1, 1'b0);

      // reset during WAIT_DONE
      drive_slot();
      req_valid = 4'b0100;
      sample_slot();
      chk("t6_ready", 32'(req_ready), 32'b0100);
      drive_slot();
      sample_slot();
      chk("t6_data", 32'(tx_p_data), 32'h33);
      drive_slot();
      tx_busy = 1'b1;
      sample_slot();
      drive_slot();
      sample_slot();
      chk("t6_wait_done", 32'(state_dbg), 32'(WAIT_DONE));
      drive_slot();
      rst       = 1'b0;
      req_valid = 4'b1111;
      sample_slot();
      chk("t6_rst_ready", 32'(req_ready), 32'd0);
      chk("t6_rst_data", 32'(tx_p_data), 32'd0);
      chk("t6_rst_grant", 32'(grant_id), 32'd0);
      chk("t6_rst_done", 32'(frame_done), 32'd0);
      chk("t6_rst_state", 32'(state_dbg), 32'(IDLE));
      drive_slot();
      rst     = 1'b1;
      tx_busy = 1'b0;
      sample_slot();
      chk("t6_after_ready", 32'(req_ready), 32'b0001);
      launch_and_finish("t6", 8'h11, 2'd0, 2, 1'b0);

      // randomized traffic with a TX core emulator
      m_ptr = 0; m_grant = 0; since = 0; busy_start = 0; busy_end = 0;
      pending = 1'b0; launch_due = 1'b0; busy_seen = 1'b0;
      acc = '0;
      drive_slot();
      req_valid = '0;
      sample_slot();
      for (int c = 0; c < 3000; c++) begin
         drive_slot();
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               req_valid[i]         = 1'($urandom_range(0, 1));
               req_data[i*DW +: DW] = DW'($urandom);
            end else if (req_valid[i]) begin
               if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               req_valid[i]         = 1'b1;
               req_data[i*DW +: DW] = DW'($urandom);
            end
         end
         acc = '0;
         if (!pending && c >= busy_end && $urandom_range(0, 15) == 0) begin
            busy_start = c;
            busy_end   = c + int'($urandom_range(1, 4));
         end
         tx_busy = (c >= busy_start) && (c < busy_end);
         sample_slot();

         exp_ready = '0;
         w = rr_ref(m_ptr, req_valid);
         if (!pending && !tx_busy && w >= 0) exp_ready = NR'(1) << w;
         chk("rand_ready", 32'(req_ready), 32'(exp_ready));

         exp_done = 1'b0;
         exp_tmo  = 1'b0;
         if (launch_due) begin
            chk("rand_launch", 32'(tx_data_valid), 32'd1);
            exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("rand_data", 32'(tx_p_data), 32'(exp_byte));
            chk("rand_grant", 32'(grant_id), 32'(m_grant));
            launch_due = 1'b0;
            since      = 0;
            busy_seen  = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
               busy_start = 0;
               busy_end   = 0;
            end else begin
               busy_start = c + int'($urandom_range(1, 3));
               busy_end   = busy_start + int'($urandom_range(1, 6));
            end
         end else begin
            chk("rand_launch", 32'(tx_data_valid), 32'd0);
            if (pending) begin
               since++;
               if (busy_seen) exp_done = !tx_busy;
               else if (tx_busy) busy_seen = 1'b1;
               else exp_tmo = (since == TMO);
            end
         end
         chk("rand_done", 32'(frame_done), 32'(exp_done));
         chk("rand_tmo", 32'(tmo_err), 32'(exp_tmo));

         if (exp_done || exp_tmo) begin
            m_ptr   = m_grant;
            pending = 1'b0;
         end
         if (exp_ready != '0) begin
            m_grant    = w;
            pending    = 1'b1;
            launch_due = 1'b1;
            exp_q.push_back(req_data[w*DW +: DW]);
            acc = exp_ready;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
